// File: rtl/uart_param_core_pkg.sv
// Shared definitions for the parametrised UART: frame-phase state encoding
// used by both the TX and RX sequencers, and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int OS_RATE = 16;
    localparam int OS_MID  = 7;

    localparam logic [3:0] OS_LAST_C = 4'(OS_RATE - 1);
    localparam logic [3:0] OS_MID_C  = 4'(OS_MID);

endpackage

// File: rtl/uart_param_core_if.sv
// Stream-side bundle of the UART: TX valid/ready input stream and RX
// valid/ready output stream with per-entry error flags and overrun status.
interface uart_param_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_perr;
    logic              rx_ferr;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;
    logic              clr_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready, clr_overrun,
        input  tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, clr_overrun,
        output tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_param_core_baud_gen.sv
// Oversample tick generator: a down-counter reloaded from baud_div, giving
// one tick every baud_div+1 clocks. A restart realigns the tick phase so
// the first tick lands exactly baud_div+1 clocks after the restart.
module uart_baud_gen #(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);
    logic [DIV_W-1:0] r_cnt;

    // Count down to zero, reload on terminal count or restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == '0)) begin
            r_cnt <= baud_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0) && !restart;
endmodule

// File: rtl/uart_param_core.sv
// 16x oversampled UART transceiver with runtime frame format, RX FIFO
// (first-word-fall-through) and sticky overrun reporting.
//
// state  | meaning
// IDLE   | line idle; TX accepts data, RX waits for a falling edge
// START  | start bit; RX re-checks the line mid-bit to reject glitches
// DATA   | DATA_W data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit(s); RX pushes on the first stop-bit sample
module uart_param_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               two_stop,
    input  logic               rx_i,
    output logic               tx_o,
    uart_param_core_if.slave   bus
);
    localparam logic [2:0] DW_LAST = 3'(DATA_W - 1);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam int         EW      = DATA_W + 2;

    // ---------------- TX ----------------
    uart_state_e       r_tx_state, w_tx_state_nx;
    logic [3:0]        r_tx_os, w_tx_os_nx;
    logic [2:0]        r_tx_bit, w_tx_bit_nx;
    logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nx;
    logic              r_tx_par, w_tx_par_nx;
    logic              r_tx_pen, w_tx_pen_nx;
    logic              r_tx_two, w_tx_two_nx;
    logic              r_tx_stop2, w_tx_stop2_nx;
    logic              r_tx_o, w_tx_o_nx;
    logic              w_tx_hs;
    logic              w_tx_tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (w_tx_hs),
        .baud_div (baud_div),
        .tick     (w_tx_tick)
    );

    // TX state and serial output register; tx_o idles high from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx_two   <= 1'b0;
            r_tx_stop2 <= 1'b0;
            r_tx_o     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_os    <= w_tx_os_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_par   <= w_tx_par_nx;
            r_tx_pen   <= w_tx_pen_nx;
            r_tx_two   <= w_tx_two_nx;
            r_tx_stop2 <= w_tx_stop2_nx;
            r_tx_o     <= w_tx_o_nx;
        end
    end

    // TX sequencing: latch frame on handshake, advance one bit per 16 ticks.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_os_nx    = r_tx_os;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_tx_par_nx   = r_tx_par;
        w_tx_pen_nx   = r_tx_pen;
        w_tx_two_nx   = r_tx_two;
        w_tx_stop2_nx = r_tx_stop2;
        w_tx_o_nx     = r_tx_o;
        w_tx_hs       = 1'b0;
        if (r_tx_state == ST_IDLE) begin
            w_tx_o_nx = 1'b1;
            if (bus.tx_valid) begin
                w_tx_hs       = 1'b1;
                w_tx_state_nx = ST_START;
                w_tx_os_nx    = '0;
                w_tx_bit_nx   = '0;
                w_tx_shift_nx = bus.tx_data;
                w_tx_par_nx   = (^bus.tx_data) ^ parity_odd;
                w_tx_pen_nx   = parity_en;
                w_tx_two_nx   = two_stop;
                w_tx_stop2_nx = 1'b0;
                w_tx_o_nx     = 1'b0;
            end
        end else if (w_tx_tick) begin
            if (r_tx_os != OS_LAST_C) begin
                w_tx_os_nx = r_tx_os + 1'b1;
            end else begin
                w_tx_os_nx = '0;
                case (r_tx_state)
                    ST_START: begin
                        w_tx_state_nx = ST_DATA;
                        w_tx_o_nx     = r_tx_shift[0];
                    end
                    ST_DATA: begin
                        if (r_tx_bit == DW_LAST) begin
                            w_tx_state_nx = r_tx_pen ? ST_PARITY : ST_STOP;
                            w_tx_o_nx     = r_tx_pen ? r_tx_par : 1'b1;
                        end else begin
                            w_tx_bit_nx   = r_tx_bit + 1'b1;
                            w_tx_shift_nx = r_tx_shift >> 1;
                            w_tx_o_nx     = r_tx_shift[1];
                        end
                    end
                    ST_PARITY: begin
                        w_tx_state_nx = ST_STOP;
                        w_tx_o_nx     = 1'b1;
                    end
                    ST_STOP: begin
                        if (r_tx_two && !r_tx_stop2) begin
                            w_tx_stop2_nx = 1'b1;
                        end else begin
                            w_tx_state_nx = ST_IDLE;
                        end
                    end
                    default: begin
                        w_tx_state_nx = ST_IDLE;
                        w_tx_o_nx     = 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_o         = r_tx_o;
    assign bus.tx_ready = (r_tx_state == ST_IDLE);

    // ---------------- RX ----------------
    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    uart_state_e       r_rx_state, w_rx_state_nx;
    logic [3:0]        r_rx_os, w_rx_os_nx;
    logic [2:0]        r_rx_bit, w_rx_bit_nx;
    logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nx;
    logic              r_rx_perr, w_rx_perr_nx;
    logic              r_push, w_push_nx;
    logic [EW-1:0]     r_push_word, w_push_word_nx;
    logic              w_rx_tick, w_rx_fall, w_rx_restart, w_rx_mid, w_rx_end;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall    = r_rx_prev & ~r_rx_sync;
    assign w_rx_restart = (r_rx_state == ST_IDLE) & w_rx_fall;
    assign w_rx_mid     = w_rx_tick & (r_rx_os == OS_MID_C);
    assign w_rx_end     = w_rx_tick & (r_rx_os == OS_LAST_C);

    uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (w_rx_restart),
        .baud_div (baud_div),
        .tick     (w_rx_tick)
    );

    // RX state, shift register and the one-cycle push staging register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= ST_IDLE;
            r_rx_os     <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_perr   <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_rx_state  <= w_rx_state_nx;
            r_rx_os     <= w_rx_os_nx;
            r_rx_bit    <= w_rx_bit_nx;
            r_rx_shift  <= w_rx_shift_nx;
            r_rx_perr   <= w_rx_perr_nx;
            r_push      <= w_push_nx;
            r_push_word <= w_push_word_nx;
        end
    end

    // RX sequencing: mid-bit sampling, glitch reject, push on first stop bit.
    always_comb begin
        w_rx_state_nx  = r_rx_state;
        w_rx_os_nx     = r_rx_os;
        w_rx_bit_nx    = r_rx_bit;
        w_rx_shift_nx  = r_rx_shift;
        w_rx_perr_nx   = r_rx_perr;
        w_push_nx      = 1'b0;
        w_push_word_nx = r_push_word;
        if ((r_rx_state != ST_IDLE) && w_rx_tick) begin
            w_rx_os_nx = r_rx_os + 1'b1;
        end
        case (r_rx_state)
            ST_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nx = ST_START;
                    w_rx_os_nx    = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_perr_nx  = 1'b0;
                end
            end
            ST_START: begin
                if (w_rx_mid && r_rx_sync) begin
                    w_rx_state_nx = ST_IDLE;
                end else if (w_rx_end) begin
                    w_rx_state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_rx_mid) begin
                    w_rx_shift_nx = {r_rx_sync, r_rx_shift[DATA_W-1:1]};
                end
                if (w_rx_end) begin
                    if (r_rx_bit == DW_LAST) begin
                        w_rx_state_nx = parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_rx_bit_nx = r_rx_bit + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_rx_mid) begin
                    w_rx_perr_nx = r_rx_sync ^ (^r_rx_shift) ^ parity_odd;
                end
                if (w_rx_end) begin
                    w_rx_state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_rx_mid) begin
                    w_push_nx      = 1'b1;
                    w_push_word_nx = {~r_rx_sync, r_rx_perr, r_rx_shift};
                    w_rx_state_nx  = ST_IDLE;
                end
            end
            default: begin
                w_rx_state_nx = ST_IDLE;
            end
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic          r_overrun;
    logic          w_empty, w_full, w_pop, w_wr_en, w_drop;
    logic [EW-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & bus.rx_ready;
    assign w_wr_en = r_push & (~w_full | w_pop);
    assign w_drop  = r_push & w_full & ~w_pop;

    // Pointer update and sticky overrun; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_push_word;
        end
    end

    assign w_head         = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.rx_valid   = ~w_empty;
    assign bus.rx_data    = w_empty ? '0 : w_head[DATA_W-1:0];
    assign bus.rx_perr    = ~w_empty & w_head[DATA_W];
    assign bus.rx_ferr    = ~w_empty & w_head[DATA_W+1];
    assign bus.rx_overrun = r_overrun;
endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: an 8-bit instance driven serially by the bench
// and a 7-bit instance in TX->RX loopback. RX entries are checked by
// per-instance monitors against queues of expected entries.
module tb_uart_param_core;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] div8, div7;
    logic        pen8, odd8, two8, pen7, odd7, two7;
    logic        rx8, tx8, tx7;

    int   checks = 0;
    int   failures = 0;
    exp_t q8[$];
    exp_t q7[$];
    exp_t m8, m7;

    uart_param_core_if #(.DATA_W(8)) if8 ();
    uart_param_core_if #(.DATA_W(7)) if7 ();

    uart_param_core #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(12)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (div8),
        .parity_en  (pen8),
        .parity_odd (odd8),
        .two_stop   (two8),
        .rx_i       (rx8),
        .tx_o       (tx8),
        .bus        (if8.slave)
    );

    uart_param_core #(.DATA_W(7), .FIFO_DEPTH(4), .DIV_W(12)) u_dut7 (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (div7),
        .parity_en  (pen7),
        .parity_odd (odd7),
        .two_stop   (two7),
        .rx_i       (tx7),
        .tx_o       (tx7),
        .bus        (if7.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: compare every popped entry against the expected queue.
    always @(negedge clk) begin
        if (rst_n && if8.rx_valid && if8.rx_ready) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx8_unexpected actual=0x%0h expected=none", if8.rx_data);
            end else begin
                m8 = q8.pop_front();
                check("rx8_data", 32'(if8.rx_data), 32'(m8.d));
                check("rx8_perr", 32'(if8.rx_perr), 32'(m8.p));
                check("rx8_ferr", 32'(if8.rx_ferr), 32'(m8.f));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if7.rx_valid && if7.rx_ready) begin
            if (q7.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx7_unexpected actual=0x%0h expected=none", if7.rx_data);
            end else begin
                m7 = q7.pop_front();
                check("rx7_data", 32'(if7.rx_data), 32'(m7.d));
                check("rx7_perr", 32'(if7.rx_perr), 32'(m7.p));
                check("rx7_ferr", 32'(if7.rx_ferr), 32'(m7.f));
            end
        end
    end

    // Serial driver for the 8-bit instance, baud_div=0 (16 clocks per bit).
    task automatic rx8_bit(input logic v);
        rx8 = v;
        clk_wait(16);
    endtask

    task automatic rx8_frame(input logic [7:0] d, input logic pb_en, input logic pb,
                             input logic stop_v);
        rx8_bit(1'b0);
        for (int i = 0; i < 8; i++) rx8_bit(d[i]);
        if (pb_en) rx8_bit(pb);
        rx8_bit(stop_v);
        rx8_bit(1'b1);
    endtask

    task automatic tx7_send(input logic [6:0] d);
        int n;
        n = 0;
        while (!if7.tx_ready && n < 5000) begin
            clk_wait(1);
            n++;
        end
        if (!if7.tx_ready) begin
            checks++;
            failures++;
            $display("FAIL tx7_ready_timeout actual=0 expected=1");
        end
        if7.tx_data  = d;
        if7.tx_valid = 1'b1;
        clk_wait(1);
        if7.tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 8) ? q8.size() : q7.size()) != 0 && n < budget) begin
            clk_wait(1);
            n++;
        end
        check((which == 8) ? "drain8_left" : "drain7_left",
              32'((which == 8) ? q8.size() : q7.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        div8 = 12'd0; pen8 = 1'b0; odd8 = 1'b0; two8 = 1'b0;
        div7 = 12'd3; pen7 = 1'b1; odd7 = 1'b0; two7 = 1'b1;
        rx8 = 1'b1;
        if8.tx_data = '0; if8.tx_valid = 1'b0; if8.rx_ready = 1'b1; if8.clr_overrun = 1'b0;
        if7.tx_data = '0; if7.tx_valid = 1'b0; if7.rx_ready = 1'b1; if7.clr_overrun = 1'b0;
        rst_n = 1'b0;
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(2);

        // Reset state
        check("rst_tx_o",     32'(tx8),            32'd1);
        check("rst_tx_ready", 32'(if8.tx_ready),   32'd1);
        check("rst_rx_valid", 32'(if8.rx_valid),   32'd0);
        check("rst_rx_data",  32'(if8.rx_data),    32'd0);
        check("rst_rx_perr",  32'(if8.rx_perr),    32'd0);
        check("rst_rx_ferr",  32'(if8.rx_ferr),    32'd0);
        check("rst_overrun",  32'(if8.rx_overrun), 32'd0);
        check("rst_tx7_o",    32'(tx7),            32'd1);

        // 7E2 loopback, baud_div=3: 0x55 then 0x2A
        q7.push_back('{d: 8'h55, p: 1'b0, f: 1'b0});
        tx7_send(7'h55);
        q7.push_back('{d: 8'h2A, p: 1'b0, f: 1'b0});
        tx7_send(7'h2A);
        wait_drain(7, 3000);

        // 8N1 TX of 0xA5 with baud_div=0: bit-exact waveform and busy window
        fr = {1'b1, 8'hA5, 1'b0};
        if8.tx_data  = 8'hA5;
        if8.tx_valid = 1'b1;
        clk_wait(1);
        if8.tx_valid = 1'b0;
        for (int i = 0; i < 160; i++) begin
            check("tx8_bit", 32'(tx8), 32'(fr[i/16]));
            check("tx8_ready_busy", 32'(if8.tx_ready), 32'd0);
            clk_wait(1);
        end
        check("tx8_ready_end", 32'(if8.tx_ready), 32'd1);
        check("tx8_idle_end",  32'(tx8),          32'd1);

        // 8O1 RX: 0x3C carrying an even-parity bit (0) -> parity error
        pen8 = 1'b1; odd8 = 1'b1;
        q8.push_back('{d: 8'h3C, p: 1'b1, f: 1'b0});
        rx8_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        wait_drain(8, 100);
        pen8 = 1'b0; odd8 = 1'b0;

        // 8N1 RX: 0x81 with stop bit 0 -> framing error, then clean 0x5A
        q8.push_back('{d: 8'h81, p: 1'b0, f: 1'b1});
        rx8_frame(8'h81, 1'b0, 1'b0, 1'b0);
        rx8_bit(1'b1);
        q8.push_back('{d: 8'h5A, p: 1'b0, f: 1'b0});
        rx8_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_drain(8, 100);

        // Overrun: five frames into a 4-deep FIFO with no reader
        if8.rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q8.push_back('{d: 8'(k), p: 1'b0, f: 1'b0});
            rx8_frame(8'(k), 1'b0, 1'b0, 1'b1);
        end
        check("ovr_set",      32'(if8.rx_overrun), 32'd1);
        check("ovr_valid",    32'(if8.rx_valid),   32'd1);
        if8.rx_ready = 1'b1;
        wait_drain(8, 100);
        clk_wait(2);
        check("ovr_empty",    32'(if8.rx_valid),   32'd0);
        check("ovr_sticky",   32'(if8.rx_overrun), 32'd1);
        if8.clr_overrun = 1'b1;
        clk_wait(1);
        if8.clr_overrun = 1'b0;
        check("ovr_cleared",  32'(if8.rx_overrun), 32'd0);

        // Glitch: 4-clock low pulse must not produce an entry
        if8.rx_ready = 1'b0;
        rx8 = 1'b0;
        clk_wait(4);
        rx8 = 1'b1;
        clk_wait(40);
        check("glitch_no_push", 32'(if8.rx_valid), 32'd0);

        // Reset mid-frame: FIFO holds one entry, TX is sending 0x00
        rx8_frame(8'h77, 1'b0, 1'b0, 1'b1);
        check("pre_rst_valid", 32'(if8.rx_valid), 32'd1);
        if8.tx_data  = 8'h00;
        if8.tx_valid = 1'b1;
        clk_wait(1);
        if8.tx_valid = 1'b0;
        clk_wait(40);
        check("pre_rst_tx_o",  32'(tx8),          32'd0);
        check("pre_rst_ready", 32'(if8.tx_ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_o",     32'(tx8),            32'd1);
        check("rst_mid_tx_ready", 32'(if8.tx_ready),   32'd1);
        check("rst_mid_rx_valid", 32'(if8.rx_valid),   32'd0);
        check("rst_mid_overrun",  32'(if8.rx_overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if8.rx_ready = 1'b1;
        clk_wait(20);
        check("post_rst_valid", 32'(if8.rx_valid), 32'd0);
        check("post_rst_tx_o",  32'(tx8),          32'd1);
        check("q8_left", 32'(q8.size()), 32'd0);
        check("q7_left", 32'(q7.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_param_core.md
# uart_param_core

Parametrised UART transceiver for the TinyTapeout tile: a 16× oversampled TX/RX pair with runtime-selectable frame format, a receive FIFO and sticky error reporting. It replaces the fixed-format UART in the top wrapper and exposes plain valid/ready streams instead of a register bus. The wrapper drives `rx_i` from a pad and sends `tx_o` to a pad.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; legal values 5–8.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `DIV_W`, 12: width of `baud_div`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_div`  in  DIV_W  clocks per 16× sample tick, minus 1; must be held static while either direction is busy.
- `parity_en`  in  1  adds a parity bit when set.
- `parity_odd`  in  1  selects odd parity when set, even when clear.
- `two_stop`  in  1  selects 2 stop bits when set, 1 when clear.
- `tx_data`  in  DATA_W  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  TX idle; a transfer happens on `tx_valid & tx_ready`.
- `rx_data`  out  DATA_W  head of the RX FIFO.
- `rx_perr`  out  1  parity error flag stored with the head entry.
- `rx_ferr`  out  1  framing error flag stored with the head entry.
- `rx_valid`  out  1  RX FIFO is not empty.
- `rx_ready`  in  1  pops the head entry when `rx_valid & rx_ready`.
- `rx_overrun`  out  1  sticky; a frame arrived while the FIFO was full.
- `clr_overrun`  in  1  clears `rx_overrun`.
- `rx_i`  in  1  serial input, asynchronous.
- `tx_o`  out  1  serial output.

## Operation
- Bit period is 16 ticks. One tick lasts `baud_div+1` clocks.
- Frame: start bit (0), then DATA_W data bits LSB first, then optional parity, then 1 or 2 stop bits (1).
- Parity:
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = the inverse of that.
- TX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - `tx_ready` is 1 only in IDLE.
  - On handshake, `tx_data` and the format inputs are latched, and the TX prescaler restarts.
  - Format inputs are sampled only at handshake.
- RX path:
  - `rx_i` passes through a 2-flop synchronizer.
  - RX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - In IDLE, a synchronized 1→0 transition restarts the RX prescaler.
  - At tick 7 of the start bit (mid-bit), the line is re-checked. If it reads 1, the edge is a glitch and the FSM returns to IDLE with no push.
  - Each later bit is sampled once at tick 7.
  - Only the first stop bit is checked. A 0 there sets `ferr` for that entry.
  - On the stop-bit sample, `{ferr, perr, data}` is pushed and the FSM returns to IDLE immediately, so a second stop bit is tolerated but not required.
- FIFO:
  - Write and read pointers are `log2(FIFO_DEPTH)+1` bits wide with wrap-bit full/empty detection.
  - A simultaneous push and pop when full is allowed; the count stays the same.
  - A push when full (and no pop in the same cycle) drops the frame and sets `rx_overrun`.
- `clr_overrun` and a same-cycle set: set wins.

## Timing
- Reset values:
  - `tx_o`=1, `tx_ready`=1.
  - `rx_valid`=0, `rx_data`=0, `rx_perr`=0, `rx_ferr`=0, `rx_overrun`=0.
  - FIFO empty; both FSMs in IDLE.
- TX latency:
  - `tx_o` falls on the first clock edge after the handshake.
  - A frame occupies 16·(baud_div+1)·(1+DATA_W+P+S) clocks, where P is 1 if parity is enabled and S is the number of stop bits.
  - `tx_ready` rises on the edge that ends the last stop bit.
- RX latency: the push lands 1 cycle after the stop-bit sample; `rx_valid` is registered from the FIFO count.
- FIFO read is first-word-fall-through: `rx_data` is valid whenever `rx_valid` is high.
- Reset asserted mid-frame:
  - Both FSMs abort.
  - `tx_o` returns to 1 asynchronously.
  - FIFO contents are discarded.

## Structure
- Shared package `uart_pkg`:
  - TX/RX state enum.
  - Tick-count constant `OS_RATE=16`.
  - Sample-point constant `OS_MID=7`.
- Sub-module `uart_baud_gen`:
  - Down-counter reloaded from `baud_div`.
  - Synchronous `restart` input.
  - `tick` output pulse.
  - Instantiated once for TX and once for RX.
- The FIFO, synchronizer and both FSMs stay inline in `uart_param_core`.

## Test plan
- 8N1, baud_div=0, send 0xA5:
  - `tx_o` is 0 for 16 clocks, then 1,0,1,0,0,1,0,1 for 16 clocks each, then 1.
  - `tx_ready` is low for exactly 160 clocks.
- 7E2 loopback (`tx_o`→`rx_i`), DATA_W=7, baud_div=3, send 0x55 then 0x2A:
  - Both bytes pop in order with `rx_perr`=0 and `rx_ferr`=0.
- 8O1 RX, drive 0x3C with an even-parity bit: the entry pops with data 0x3C and `rx_perr`=1.
- 8N1 RX, drive 0x81 with the stop bit forced to 0: the entry pops with data 0x81 and `rx_ferr`=1; the next clean frame is received correctly.
- FIFO_DEPTH=4, `rx_ready`=0, send 5 frames 0x01..0x05:
  - `rx_overrun`=1.
  - Popping yields 0x01..0x04, then `rx_valid`=0.
  - `clr_overrun` clears the flag.
- Glitch and reset:
  - A 4-clock low pulse on `rx_i` (baud_div=0) pushes nothing.
  - Asserting `rst_n`=0 mid-TX frame forces `tx_o`=1 and `tx_ready`=1, and empties the FIFO.
